// File: rtl/mem_boot_loader.sv
// mem_boot_loader
//   Boot-time loader and arbiter for the data_memory write port.
//   External words arrive over a valid/ready handshake. Each word goes into a
//   small FIFO and is written to memory one word per cycle. The CPU is held
//   halted until the external load is finished and the FIFO has drained.
//   After that the memory write port is handed to the CPU.
//
// Optional feature: MEM_BOOT_RUNTIME_LOAD_EN
//   When defined, external words are also accepted in RUN. CPU stores have
//   priority on the port. Buffered words are written on cycles where the CPU
//   does not store. These runtime words are not counted in boot_count.
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   reset         asynchronous, active-low; 0 clears all state at once
//   ext_valid     external word valid
//   ext_ready     loader can take the external word this cycle
//   ext_addr      external byte address; must be word aligned
//   ext_data      external data word
//   ext_done      single-cycle pulse: external load finished
//   cpu_mem_write CPU store enable
//   cpu_addr      CPU store address
//   cpu_wdata     CPU store data
//   mem_write     write enable to data_memory
//   mem_addr      address to data_memory
//   mem_wdata     data to data_memory
//   cpu_halt      1 = CPU holds its PC and suppresses stores
//   boot_count    number of words written during boot (saturates)
//   boot_err      sticky flag: a misaligned external word was dropped
//   state_dbg     current FSM state (0 BOOT, 1 DRAIN, 2 RUN)
//
// Handshake: a transfer happens at a rising edge where ext_valid and
// ext_ready are both 1. ext_ready depends only on registered state and never
// on ext_valid. When the FIFO is full, a pop in the same cycle does not open
// a slot for a push in that cycle. A transfer whose address is misaligned
// still completes, but the word is discarded and boot_err is set.
module mem_boot_loader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              ext_done,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_halt,
  output logic [CNT_W-1:0]  boot_count,
  output logic              boot_err,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, occ;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [CNT_W-1:0]  boot_count_q;
  logic              boot_err_q;
  logic              empty, full, loading, hs, push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // Pointers carry one extra wrap bit. The FIFO is full when the index bits
  // match and the wrap bits differ.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign occ       = wr_ptr - rd_ptr;
  assign loading   = (state_q != RUN);
  assign head_addr = fifo_addr[rd_ptr[IDX_W-1:0]];
  assign head_data = fifo_data[rd_ptr[IDX_W-1:0]];

  // ext_ready is gated with reset so it reads 0 while reset is held.
`ifdef MEM_BOOT_RUNTIME_LOAD_EN
  assign ext_ready = reset && !full && (state_q != DRAIN);
  assign pop       = !empty && (loading || !cpu_mem_write);
`else
  assign ext_ready = reset && !full && (state_q == BOOT);
  assign pop       = !empty && loading;
`endif

  assign hs   = ext_valid && ext_ready;
  assign push = hs && (ext_addr[1:0] == 2'b00);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (ext_done) state_d = DRAIN;
      // DRAIN never accepts pushes, so the FIFO empties when the last entry pops.
      DRAIN:   if (empty || (occ == PTR_W'(1))) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Memory-port mux. In RUN the CPU passes through with no added latency.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == RUN) begin
      mem_write = cpu_mem_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
`ifdef MEM_BOOT_RUNTIME_LOAD_EN
      if (pop) begin
        mem_write = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
`endif
    end else if (pop) begin
      mem_write = 1'b1;
      mem_addr  = head_addr;
      mem_wdata = head_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      boot_count_q <= '0;
      boot_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop && loading && (boot_count_q != {CNT_W{1'b1}}))
        boot_count_q <= boot_count_q + CNT_W'(1);
      if (hs && (ext_addr[1:0] != 2'b00)) boot_err_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[IDX_W-1:0]] <= ext_addr;
      fifo_data[wr_ptr[IDX_W-1:0]] <= ext_data;
    end
  end

  // cpu_halt is decoded from the state register, so it falls on the cycle
  // after the edge that moves the FSM to RUN.
  assign cpu_halt   = (state_q != RUN);
  assign boot_count = boot_count_q;
  assign boot_err   = boot_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed testbench for mem_boot_loader.
module tb_mem_boot_loader;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
`ifdef MEM_BOOT_RUNTIME_LOAD_EN
  localparam logic RUN_READY = 1'b1;
`else
  localparam logic RUN_READY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ext_valid;
  logic        ext_ready;
  logic [31:0] ext_addr;
  logic [31:0] ext_data;
  logic        ext_done;
  logic        cpu_mem_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_halt;
  logic [15:0] boot_count;
  logic        boot_err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  mem_boot_loader #(.DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ext_valid(ext_valid), .ext_ready(ext_ready),
    .ext_addr(ext_addr), .ext_data(ext_data), .ext_done(ext_done),
    .cpu_mem_write(cpu_mem_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_halt(cpu_halt), .boot_count(boot_count), .boot_err(boot_err),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic done, input logic cw, input logic [31:0] ca,
                     input logic [31:0] cd);
    @(posedge clk);
    #1;
    ext_valid     = v;
    ext_addr      = a;
    ext_data      = d;
    ext_done      = done;
    cpu_mem_write = cw;
    cpu_addr      = ca;
    cpu_wdata     = cd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    ext_valid     = 1'b0;
    ext_done      = 1'b0;
    cpu_mem_write = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20; i++) begin
      if (!cpu_halt) break;
      idle();
    end
    check("run_reached", {63'h0, cpu_halt}, 64'h0);
  endtask

  // Scoreboard: every memory write while the CPU is halted must match the
  // next expected boot word, in order.
  always @(negedge clk) begin
    if (reset && mem_write && cpu_halt) begin
      if (exp_q.size() == 0)
        check("unexpected_write", {mem_addr, mem_wdata}, 64'hDEAD_DEAD_DEAD_DEAD);
      else
        check("boot_write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; ext_valid = 1'b1; ext_addr = '0; ext_data = '0; ext_done = 1'b0;
    cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state, sampled before the first clock edge
    #3;
    check("rst_ready",  {63'h0, ext_ready}, 64'h0);
    check("rst_halt",   {63'h0, cpu_halt},  64'h1);
    check("rst_mw",     {63'h0, mem_write}, 64'h0);
    check("rst_maddr",  {32'h0, mem_addr},  64'h0);
    check("rst_mdata",  {32'h0, mem_wdata}, 64'h0);
    check("rst_count",  {48'h0, boot_count}, 64'h0);
    check("rst_err",    {63'h0, boot_err},  64'h0);
    check("rst_state",  {62'h0, state_dbg}, {62'h0, S_BOOT});

    // T1: three back-to-back words, ext_done arriving with the last one
    do_reset();
    exp_q.push_back({32'h0, 32'hA});
    cyc(1, 32'h0, 32'hA, 0, 0, 0, 0);
    check("t1_ready0", {63'h0, ext_ready}, 64'h1);
    check("t1_lat0",   {63'h0, mem_write}, 64'h0);
    exp_q.push_back({32'h4, 32'hB});
    cyc(1, 32'h4, 32'hB, 0, 0, 0, 0);
    check("t1_lat1",   {63'h0, mem_write}, 64'h1);
    exp_q.push_back({32'h8, 32'hC});
    cyc(1, 32'h8, 32'hC, 1, 0, 0, 0);
    check("t1_state_boot", {62'h0, state_dbg}, {62'h0, S_BOOT});
    check("t1_mw2",        {63'h0, mem_write}, 64'h1);
    idle();
    check("t1_state_drain", {62'h0, state_dbg}, {62'h0, S_DRAIN});
    check("t1_halt_drain",  {63'h0, cpu_halt},  64'h1);
    check("t1_mw3",         {63'h0, mem_write}, 64'h1);
    cyc(0, 32'h0, 32'h0, 1, 1, 32'h100, 32'h55);
    check("t1_state_run", {62'h0, state_dbg}, {62'h0, S_RUN});
    check("t1_halt_run",  {63'h0, cpu_halt},  64'h0);
    check("t1_count",     {48'h0, boot_count}, 64'd3);
    check("t1_ready_run", {63'h0, ext_ready}, {63'h0, RUN_READY});
    check("t1_cpu_mw",    {63'h0, mem_write}, 64'h1);
    check("t1_cpu_addr",  {32'h0, mem_addr},  64'h100);
    check("t1_cpu_data",  {32'h0, mem_wdata}, 64'h55);
    check("t1_q_empty",   exp_q.size(), 64'h0);
    cyc(0, 32'h0, 32'h0, 0, 0, 32'h200, 32'h66);
    check("t1_cpu_mw0",   {63'h0, mem_write}, 64'h0);
    check("t1_cpu_addr2", {32'h0, mem_addr},  64'h200);
    check("t1_state_run2", {62'h0, state_dbg}, {62'h0, S_RUN});

    // T2: ext_valid held for five words; ready never drops
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({32'(i * 4), 32'(32'h100 + i)});
      cyc(1, 32'(i * 4), 32'(32'h100 + i), 0, 0, 0, 0);
      check("t2_ready", {63'h0, ext_ready}, 64'h1);
    end
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    wait_run();
    check("t2_count",   {48'h0, boot_count}, 64'd5);
    check("t2_q_empty", exp_q.size(), 64'h0);

    // T3: misaligned address is dropped and flagged
    do_reset();
    exp_q.push_back({32'h0, 32'h1});
    cyc(1, 32'h0, 32'h1, 0, 0, 0, 0);
    check("t3_err0", {63'h0, boot_err}, 64'h0);
    cyc(1, 32'h6, 32'h2, 0, 0, 0, 0);
    check("t3_ready_mis", {63'h0, ext_ready}, 64'h1);
    check("t3_err1",      {63'h0, boot_err},  64'h0);
    exp_q.push_back({32'h8, 32'h3});
    cyc(1, 32'h8, 32'h3, 1, 0, 0, 0);
    check("t3_err_set", {63'h0, boot_err}, 64'h1);
    wait_run();
    check("t3_err_run", {63'h0, boot_err},   64'h1);
    check("t3_count",   {48'h0, boot_count}, 64'd2);
    idle();
    check("t3_err_sticky", {63'h0, boot_err}, 64'h1);
    check("t3_q_empty",    exp_q.size(), 64'h0);

    // T4: ext_done in the same cycle as the fourth accepted word
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'(32'h10 + i * 4), 32'(32'hC0 + i)});
      cyc(1, 32'(32'h10 + i * 4), 32'(32'hC0 + i), (i == 3), 0, 0, 0);
    end
    cyc(1, 32'h40, 32'h99, 0, 0, 0, 0);
    check("t4_state_drain", {62'h0, state_dbg}, {62'h0, S_DRAIN});
    check("t4_ready_drain", {63'h0, ext_ready}, 64'h0);
    check("t4_mw_last",     {63'h0, mem_write}, 64'h1);
    idle();
    check("t4_state_run", {62'h0, state_dbg}, {62'h0, S_RUN});
    check("t4_count",     {48'h0, boot_count}, 64'd4);
    check("t4_mw_run",    {63'h0, mem_write}, 64'h0);
    check("t4_q_empty",   exp_q.size(), 64'h0);

    // T5: asynchronous reset in the middle of a cycle with a word pending
    do_reset();
    exp_q.push_back({32'h0, 32'hA1});
    cyc(1, 32'h0, 32'hA1, 0, 0, 0, 0);
    exp_q.push_back({32'h4, 32'hB2});
    cyc(1, 32'h4, 32'hB2, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    ext_valid = 1'b0;
    check("t5_pending", {63'h0, mem_write}, 64'h1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_mw",    {63'h0, mem_write}, 64'h0);
    check("t5_maddr", {32'h0, mem_addr},  64'h0);
    check("t5_mdata", {32'h0, mem_wdata}, 64'h0);
    check("t5_ready", {63'h0, ext_ready}, 64'h0);
    check("t5_halt",  {63'h0, cpu_halt},  64'h1);
    check("t5_count", {48'h0, boot_count}, 64'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t5_no_stale", {63'h0, mem_write}, 64'h0);
    end
    check("t5_count_after", {48'h0, boot_count}, 64'h0);

`ifdef MEM_BOOT_RUNTIME_LOAD_EN
    // T6: runtime load, CPU stores take priority over a buffered word
    do_reset();
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    wait_run();
    cyc(1, 32'h20, 32'h77, 0, 0, 0, 0);
    check("t6_ready", {63'h0, ext_ready}, 64'h1);
    check("t6_mw0",   {63'h0, mem_write}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h0, 32'h0, 0, 1, 32'(32'h300 + i * 4), 32'(i + 1));
      check("t6_cpu_mw",   {63'h0, mem_write}, 64'h1);
      check("t6_cpu_addr", {32'h0, mem_addr},  {32'h0, 32'(32'h300 + i * 4)});
      check("t6_cpu_data", {32'h0, mem_wdata}, {32'h0, 32'(i + 1)});
      check("t6_halt",     {63'h0, cpu_halt},  64'h0);
    end
    idle();
    check("t6_ext_mw",   {63'h0, mem_write}, 64'h1);
    check("t6_ext_addr", {32'h0, mem_addr},  64'h20);
    check("t6_ext_data", {32'h0, mem_wdata}, 64'h77);
    idle();
    check("t6_mw_done", {63'h0, mem_write},  64'h0);
    check("t6_count",   {48'h0, boot_count}, 64'h0);
`endif

    check("final_q_empty", exp_q.size(), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
